// File: rtl/lag_pl_output_allocator_pkg.sv
// Shared types and defaults for the physical-lane allocators.
package lag_pl_output_allocator_pkg;

    localparam int NUM_REQS_DEF       = 32'sd5;
    localparam int NUM_PLS_GLOBAL_DEF = 32'sd4;

    // Index width for a vector of n entries; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    localparam int PL_ID_W_DEF = id_width(NUM_PLS_GLOBAL_DEF);

    typedef logic [PL_ID_W_DEF-1:0] pl_id_t;

endpackage

// File: rtl/lag_pl_output_allocator_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer (wrapping). The pointer moves past the winner only when advance is set.
module lag_rr_arbiter
    import lag_pl_output_allocator_pkg::*;
#(
    parameter int num_reqs = NUM_REQS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [num_reqs-1:0] req,
    input  logic                advance,
    output logic [num_reqs-1:0] gnt
);

    localparam int ptr_w = id_width(num_reqs);

    logic [ptr_w-1:0] ptr_q;
    logic [ptr_w-1:0] ptr_d;
    logic [ptr_w-1:0] idx_s;
    logic [ptr_w-1:0] win_s;
    logic             found_s;
    logic             hit_s;
    int               sum_v;

    // Scan requesters starting at the pointer; first hit wins.
    always_comb begin
        gnt     = '0;
        win_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        sum_v   = 32'sd0;
        for (int k = 0; k < num_reqs; k++) begin
            sum_v        = int'(ptr_q) + k;
            idx_s        = (sum_v >= num_reqs) ? ptr_w'(sum_v - num_reqs) : ptr_w'(sum_v);
            hit_s        = !found_s && req[idx_s];
            gnt[idx_s]   = gnt[idx_s] | hit_s;
            win_s        = hit_s ? idx_s : win_s;
            found_s      = found_s | hit_s;
        end
    end

    // Next pointer: one past the winner, wrapping at num_reqs-1.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found_s) begin
            ptr_d = (win_s == ptr_w'(num_reqs - 1)) ? '0 : win_s + ptr_w'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset gives requester 0 highest priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lag_pl_output_allocator.sv
// Per-output-port PL allocator: hands out at most one free PL per cycle to a
// round-robin chosen requester and strobes the allocated PL back to the pool.
module lag_pl_output_allocator
    import lag_pl_output_allocator_pkg::*;
#(
    parameter  int num_reqs       = NUM_REQS_DEF,
    parameter  int num_pls_global = NUM_PLS_GLOBAL_DEF,
    localparam int pl_id_w        = id_width(num_pls_global)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [num_reqs-1:0]       req,
    input  logic [num_pls_global-1:0] pl_alloc_status,
    output logic [num_reqs-1:0]       gnt,
    output logic                      gnt_valid,
    output logic [pl_id_w-1:0]        gnt_pl,
    output logic [num_pls_global-1:0] pl_allocated
);

    logic [num_reqs-1:0]       gnt_q, gnt_d;
    logic                      gnt_valid_q, gnt_valid_d;
    logic [pl_id_w-1:0]        gnt_pl_q, gnt_pl_d;
    logic [num_pls_global-1:0] pl_alloc_q, pl_alloc_d;

    logic [num_reqs-1:0]       eligible_s;
    logic [num_pls_global-1:0] free_s;
    logic [num_reqs-1:0]       arb_gnt_s;
    logic [pl_id_w-1:0]        pl_sel_s;
    logic                      pl_found_s;
    logic [num_pls_global-1:0] pl_onehot_s;
    logic                      grant_s;

    // A requester granted last cycle still shows req, and the pool still shows
    // the PL just strobed; both are masked so nothing is issued twice.
    assign eligible_s = req & ~gnt_q;
    assign free_s     = pl_alloc_status & ~pl_alloc_q;
    assign grant_s    = (|eligible_s) & pl_found_s;

    lag_rr_arbiter #(
        .num_reqs (num_reqs)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (eligible_s),
        .advance (grant_s),
        .gnt     (arb_gnt_s)
    );

    // Lowest-index free PL.
    always_comb begin
        pl_sel_s   = '0;
        pl_found_s = 1'b0;
        for (int p = 0; p < num_pls_global; p++) begin
            pl_sel_s   = (!pl_found_s && free_s[p]) ? pl_id_w'(p) : pl_sel_s;
            pl_found_s = pl_found_s | free_s[p];
        end
    end

    // Next-cycle outputs: all zero unless a requester and a PL are both available.
    always_comb begin
        pl_onehot_s           = '0;
        pl_onehot_s[pl_sel_s] = 1'b1;
        if (grant_s) begin
            gnt_d       = arb_gnt_s;
            gnt_valid_d = 1'b1;
            gnt_pl_d    = pl_sel_s;
            pl_alloc_d  = pl_onehot_s;
        end else begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_pl_d    = '0;
            pl_alloc_d  = '0;
        end
    end

    // Output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_pl_q    <= '0;
            pl_alloc_q  <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_pl_q    <= gnt_pl_d;
            pl_alloc_q  <= pl_alloc_d;
        end
    end

    assign gnt          = gnt_q;
    assign gnt_valid    = gnt_valid_q;
    assign gnt_pl       = gnt_pl_q;
    assign pl_allocated = pl_alloc_q;

endmodule

// File: tb/tb_lag_pl_output_allocator.sv
// Self-checking bench for lag_pl_output_allocator: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_lag_pl_output_allocator;

    localparam int NR = 5;
    localparam int NP = 4;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [NP-1:0] pl_alloc_status;
    logic [NR-1:0] gnt;
    logic          gnt_valid;
    logic [1:0]    gnt_pl;
    logic [NP-1:0] pl_allocated;

    int tests = 0;
    int fails = 0;

    // Model state: the outputs currently expected, and the round-robin pointer.
    logic [NR-1:0] m_gnt   = '0;
    logic [NP-1:0] m_pl    = '0;
    logic [1:0]    m_gpl   = '0;
    logic          m_valid = 1'b0;
    int            m_ptr   = 0;

    lag_pl_output_allocator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .pl_alloc_status (pl_alloc_status),
        .gnt             (gnt),
        .gnt_valid       (gnt_valid),
        .gnt_pl          (gnt_pl),
        .pl_allocated    (pl_allocated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the registered outputs, clock, compare.
    task automatic step(input logic [NR-1:0] r, input logic [NP-1:0] s, input logic rn);
        logic [NR-1:0] elig;
        logic [NP-1:0] fr;
        logic [NR-1:0] ng;
        logic [NP-1:0] npl;
        logic [1:0]    ngpl;
        logic          nv;
        int            nptr;
        bit            fw;
        bit            fp;
        req             = r;
        pl_alloc_status = s;
        rst_n           = rn;
        ng   = '0;
        npl  = '0;
        ngpl = '0;
        nv   = 1'b0;
        nptr = m_ptr;
        if (!rn) begin
            nptr = 0;
        end else begin
            elig = r & ~m_gnt;
            fr   = s & ~m_pl;
            if (elig != 0 && fr != 0) begin
                fw = 0;
                for (int k = 0; k < NR; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NR;
                    if (!fw && elig[idx]) begin
                        fw = 1;
                        ng[idx] = 1'b1;
                        nptr = (idx + 1) % NR;
                    end
                end
                fp = 0;
                for (int p = 0; p < NP; p++) begin
                    if (!fp && fr[p]) begin
                        fp = 1;
                        npl[p] = 1'b1;
                        ngpl = 2'(p);
                    end
                end
                nv = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_gnt = ng; m_pl = npl; m_gpl = ngpl; m_valid = nv; m_ptr = nptr;
        check("gnt",          32'(gnt),          32'(m_gnt));
        check("gnt_valid",    32'(gnt_valid),    32'(m_valid));
        check("gnt_pl",       32'(gnt_pl),       32'(m_gpl));
        check("pl_allocated", 32'(pl_allocated), 32'(m_pl));
        check("onehot0_gnt",  32'($onehot0(gnt)), 32'd1);
        check("onehot0_pl",   32'($onehot0(pl_allocated)), 32'd1);
        check("popcount_eq",  32'($countones(gnt)), 32'($countones(pl_allocated)));
        check("gnt_pl_range", 32'(gnt_pl < 2'(NP - 1) || gnt_pl == 2'(NP - 1)), 32'd1);
        if (rn && gnt_valid) check("pl_was_free", 32'(s[gnt_pl]), 32'd1);
    endtask

    logic [NP-1:0] pool;
    logic [NR-1:0] rq;
    logic [NR-1:0] prev_g;
    logic [NP-1:0] strobe;
    logic          rn_r;
    int            wait_c [NR];

    initial begin
        req = '0; pl_alloc_status = '0; rst_n = 1'b0;
        #1;
        // 1: reset, single requester, then the masked repeat.
        step(5'b00000, 4'b0000, 1'b0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_pl",  32'(pl_allocated), 32'd0);
        step(5'b00001, 4'b1111, 1'b1);
        check("t1_gnt", 32'(gnt), 32'h01);
        check("t1_pl",  32'(gnt_pl), 32'd0);
        check("t1_alloc", 32'(pl_allocated), 32'h1);
        step(5'b00001, 4'b1111, 1'b1);
        check("t1_masked", 32'(gnt), 32'd0);

        // 2: all requesting, grants rotate 0..4,0 with PLs alternating 0/1.
        step(5'b00000, 4'b0000, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(5'b11111, 4'b1111, 1'b1);
            check("t2_gnt", 32'(gnt), 32'(1 << (k % NR)));
            check("t2_pl",  32'(gnt_pl), 32'(k % 2));
        end

        // 3: no free PL, then PL2 frees, then not regranted while strobed.
        step(5'b00000, 4'b0000, 1'b0);
        step(5'b00110, 4'b0000, 1'b1);
        check("t3_none", 32'(gnt_valid), 32'd0);
        step(5'b00110, 4'b0100, 1'b1);
        check("t3_gnt", 32'(gnt), 32'h02);
        check("t3_pl",  32'(gnt_pl), 32'd2);
        step(5'b00110, 4'b0100, 1'b1);
        check("t3_noregrant", 32'(gnt_valid), 32'd0);

        // 4: pointer at 4, wrap-around.
        step(5'b00000, 4'b0000, 1'b0);
        step(5'b01000, 4'b1111, 1'b1);
        check("t4_g3", 32'(gnt), 32'h08);
        step(5'b10001, 4'b1111, 1'b1);
        check("t4_g4", 32'(gnt), 32'h10);
        step(5'b10001, 4'b1111, 1'b1);
        check("t4_g0", 32'(gnt), 32'h01);

        // 5: reset mid-operation clears outputs and pointer.
        step(5'b00000, 4'b0000, 1'b0);
        step(5'b00100, 4'b1111, 1'b1);
        check("t5_g2", 32'(gnt), 32'h04);
        step(5'b11111, 4'b1111, 1'b0);
        check("t5_rst_gnt", 32'(gnt), 32'd0);
        check("t5_rst_pl",  32'(pl_allocated), 32'd0);
        step(5'b11111, 4'b1111, 1'b1);
        check("t5_ptr0", 32'(gnt), 32'h01);

        // 6: random traffic with a free-pool model and fairness tracking.
        step(5'b00000, 4'b0000, 1'b0);
        pool = 4'b1111;
        rq   = '0;
        for (int i = 0; i < NR; i++) wait_c[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!(rq[i] && !m_gnt[i])) rq[i] = ($urandom_range(0, 2) == 0);
            end
            rn_r   = ($urandom_range(0, 499) != 0);
            strobe = m_pl;
            prev_g = m_gnt;
            step(rq, pool, rn_r);
            if (!rn_r) begin
                pool = 4'b1111;
                rq   = '0;
                for (int i = 0; i < NR; i++) wait_c[i] = 0;
            end else begin
                pool = pool & ~strobe;
                if ($urandom_range(0, 3) == 0) pool = pool | 4'($urandom_range(0, 15));
                for (int i = 0; i < NR; i++) begin
                    if (m_gnt[i]) begin
                        check("fair_wait", 32'(wait_c[i] <= NR - 1), 32'd1);
                        wait_c[i] = 0;
                    end else if (rq[i] && !prev_g[i] && m_gnt != 0) begin
                        wait_c[i]++;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
